// File: rtl/arb_pkg.sv
// Shared constants and state type for the round-robin grant encoder.
// Optional feature macro: ARB_TIMEOUT_EN (forced release after a bounded hold).
package arb_pkg;

  localparam int unsigned N_REQ            = 4;
  localparam int unsigned IDX_W            = 2;
  localparam int unsigned DEFAULT_MAX_HOLD = 16;

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } arb_state_e;

endpackage

// File: rtl/rr_grant_encoder_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// Optional feature macro: ARB_TIMEOUT_EN adds the timeout pulse.
interface rr_grant_encoder_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_en;
  logic             busy;
`ifdef ARB_TIMEOUT_EN
  logic             timeout;
`endif

  modport master (
    output req,
    output done,
`ifdef ARB_TIMEOUT_EN
    input  timeout,
`endif
    input  grant_idx,
    input  grant_en,
    input  busy
  );

  modport slave (
    input  req,
    input  done,
`ifdef ARB_TIMEOUT_EN
    output timeout,
`endif
    output grant_idx,
    output grant_en,
    output busy
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotating-priority finder: first set request scanning ptr, ptr+1, ... mod N_REQ.
// Unaffected by the ARB_TIMEOUT_EN macro.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  // Scan from the far end back toward ptr so the closest set bit is the last write.
  always_comb begin
    logic [IDX_W-1:0] idx;
    winner = '0;
    idx    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = ptr + IDX_W'(i);
      if (req[idx]) begin
        winner = idx;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter producing an encoded grant index and enable for a 2-to-4 decoder.
// Optional feature macro: ARB_TIMEOUT_EN forces release after MAX_HOLD grant cycles.
module rr_grant_encoder
  import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
  parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD
)
`endif
(
  input  logic              clk,
  input  logic              rst_n,
  rr_grant_encoder_if.slave bus
);

  arb_state_e       state_q;
  logic [IDX_W-1:0] grant_idx_q;
  logic [IDX_W-1:0] ptr_q;
  logic             grant_en_q;
  logic             busy_q;
  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic             release_req;

  rr_pick u_pick (
    .req     (bus.req),
    .ptr     (ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [CntW-1:0] hold_cnt_q;
  logic            timeout_q;
  logic            owner_release;
  logic            force_release;

  assign owner_release = bus.done || !bus.req[grant_idx_q];
  // Timeout only claims the release when the owner did not release on its own.
  assign force_release = !owner_release && (hold_cnt_q == CntW'(MAX_HOLD - 1));
  assign release_req   = owner_release || force_release;
  assign bus.timeout   = timeout_q;
`else
  assign release_req   = bus.done || !bus.req[grant_idx_q];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      grant_idx_q <= '0;
      grant_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      ptr_q       <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q  <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            grant_idx_q <= winner;
            grant_en_q  <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= StGrant;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q  <= '0;
`endif
          end
        end
        StGrant: begin
`ifdef ARB_TIMEOUT_EN
          hold_cnt_q <= hold_cnt_q + 1'b1;
`endif
          if (release_req) begin
            grant_en_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= StIdle;
            ptr_q      <= grant_idx_q + 1'b1;
`ifdef ARB_TIMEOUT_EN
            timeout_q  <= force_release;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.grant_idx = grant_idx_q;
  assign bus.grant_en  = grant_en_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Scoreboard bench for rr_grant_encoder: directed plan plus randomized traffic.
// Build with ARB_TIMEOUT_EN to exercise the forced-release path (MAX_HOLD = 4).
module tb_rr_grant_encoder;
  import arb_pkg::*;

  localparam int TmoHold = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TmoOn = 1'b1;
`else
  localparam bit TmoOn = 1'b0;
`endif

  typedef struct packed {
    logic       en;
    logic [1:0] idx;
    logic       busy;
    logic       tmo;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rr_grant_encoder_if bus ();

`ifdef ARB_TIMEOUT_EN
  rr_grant_encoder #(.MAX_HOLD(TmoHold)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
  rr_grant_encoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   grant_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: who owns the grant (-1 = nobody), last granted index, rotation start.
  int m_owner = -1;
  int m_last  = 0;
  int m_ptr   = 0;
  int m_held  = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 0;
    m_ptr   = 0;
    m_held  = 0;
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after the next rising edge.
  task automatic step(input logic [3:0] r, input logic d);
    exp_t e;
    bit   rel_nat;
    bit   rel_tmo;
    bit   tmo_exp;
    @(negedge clk);
    #1;
    bus.req  = r;
    bus.done = d;
    tmo_exp  = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          m_last  = m_owner;
          m_held  = 0;
        end
      end
    end else begin
      rel_nat = d || !r[m_owner];
      rel_tmo = TmoOn && !rel_nat && (m_held == TmoHold - 1);
      if (rel_nat || rel_tmo) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        tmo_exp = rel_tmo;
      end else begin
        m_held++;
      end
    end
    e.en   = (m_owner >= 0);
    e.idx  = 2'(m_last);
    e.busy = (m_owner >= 0);
    e.tmo  = tmo_exp;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every cycle, and check each new grant against the directed list.
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    int   g;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("grant_en", int'(bus.grant_en), int'(e.en));
      check("grant_idx", int'(bus.grant_idx), int'(e.idx));
      check("busy", int'(bus.busy), int'(e.busy));
`ifdef ARB_TIMEOUT_EN
      check("timeout", int'(bus.timeout), int'(e.tmo));
`endif
      if (bus.grant_en && !prev_en && grant_q.size() > 0) begin
        g = grant_q.pop_front();
        check("grant_start_idx", int'(bus.grant_idx), g);
      end
    end
    prev_en = bus.grant_en;
  end

  initial begin
    logic [3:0] r;
    bus.req  = '0;
    bus.done = 1'b0;
    model_reset();
    #3;
    check("reset_grant_en", int'(bus.grant_en), 0);
    check("reset_grant_idx", int'(bus.grant_idx), 0);
    check("reset_busy", int'(bus.busy), 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Single requester, done pulse releases; ptr -> 1.
    grant_q.push_back(0);
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b1);
    step(4'b0000, 1'b0);
    step(4'b0001, 1'b1);   // done in idle is ignored, but req is arbitrated (ptr=1 -> 0)
    grant_q.push_back(0);
    step(4'b0000, 1'b0);   // owner drops, ptr -> 1

    // Owner 2 drops its request without done; ptr -> 3.
    grant_q.push_back(2);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);

    // ptr=3 with req 1001 grants 3, then wraps to 0.
    grant_q.push_back(3);
    step(4'b1001, 1'b0);
    step(4'b1001, 1'b1);
    grant_q.push_back(0);
    step(4'b1001, 1'b0);
    step(4'b1001, 1'b1);
    step(4'b0000, 1'b0);

    // Asynchronous reset while index 2 is granted.
    grant_q.push_back(2);
    step(4'b0100, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_grant_en", int'(bus.grant_en), 0);
    check("async_rst_grant_idx", int'(bus.grant_idx), 0);
    check("async_rst_busy", int'(bus.busy), 0);
    bus.req  = '0;
    bus.done = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // All requesting, done each grant: 0,1,2,3,0 with an idle cycle between.
    for (int i = 0; i < 5; i++) begin
      grant_q.push_back(i % 4);
      step(4'b1111, 1'b0);
      step(4'b1111, 1'b1);
    end
    step(4'b0000, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // Held request with no done: forced release after TmoHold cycles, then regrant.
    grant_q.push_back(2);
    grant_q.push_back(2);
    for (int i = 0; i < 7; i++) step(4'b0100, 1'b0);
    step(4'b0100, 1'b1);
    step(4'b0000, 1'b0);
`endif

    // Randomized traffic with sticky request patterns.
    r = 4'($urandom_range(0, 15));
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      step(r, ($urandom_range(0, 4) == 0));
    end
    step(4'b0000, 1'b0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_grant_encoder.md
Name: rr_grant_encoder

Overview:
- Round-robin arbiter feeding the 2-to-4 select decoder directly downstream.
- Accepts four request lines and grants exactly one at a time.
- Presents the winner as a 2-bit encoded index plus an enable; these drive the decoder's in[1:0] and en.
- Grant is held until the owner releases it; rotating priority guarantees fairness.

Parameters:
- N_REQ, 4, number of requesters (fixed at 4 to match decoder width)
- IDX_W, 2, width of encoded grant index (log2 N_REQ)
- MAX_HOLD, 16, max cycles a grant may be held; used only with ARB_TIMEOUT_EN

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  4  request lines, level-sensitive, bit i = requester i
- done  input  1  single-cycle release pulse from current owner
- grant_idx  output  2  encoded index of current owner, registered
- grant_en  output  1  grant valid, registered; drives decoder en
- busy  output  1  high while state is GRANT
- timeout  output  1  one-cycle pulse on forced release (present only with ARB_TIMEOUT_EN)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, grant_idx=2'b00, grant_en=0, busy=0, ptr=2'b00, hold_cnt=0, timeout=0.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0 at a clock edge: winner = first set bit scanning ptr, ptr+1, ... (mod 4).
  - On that edge: grant_idx<=winner, grant_en<=1, state<=GRANT.
  - Latency from sampled request to grant_en: 1 cycle.
  - If req==0: outputs hold; grant_en stays 0.
- GRANT: release occurs when any of the following is true at an edge:
  - done=1;
  - req[grant_idx]=0 (owner dropped its request);
  - the timeout condition fires.
- On release:
  - grant_en<=0, state<=IDLE, ptr<=grant_idx+1 (mod 4, wraps 3->0).
  - grant_idx holds its last value.
  - Exactly one idle cycle separates consecutive grants, so the decoder sees en=0 between owners.
- Simultaneous events:
  - done and a new req from another master on the same edge: release first; the new req is arbitrated in the following IDLE cycle.
  - done asserted in IDLE: ignored.
- New requests arriving during GRANT are never pre-empting.
- busy = (state==GRANT); it is registered and mirrors grant_en.
- Reset mid-grant: grant_en drops asynchronously and ptr returns to 0.
- No X propagation: req bits with X are not legal input; the bench does not drive them.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With macro defined:
  - hold_cnt clears on grant and increments each GRANT cycle.
  - When hold_cnt==MAX_HOLD-1 and no other release is present, a forced release occurs and timeout pulses high for 1 cycle.
  - Release behaviour and ptr update are as for a normal release.
- Without macro:
  - No hold_cnt and no timeout port.
  - A grant is held indefinitely until done or the owner drops its request.

Decomposition:
- Package arb_pkg: N_REQ, IDX_W, default MAX_HOLD, state enum (IDLE, GRANT).
- Sub-module rr_pick: combinational rotate-priority finder.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: winner[1:0], any_req.
  - Instantiated once.
- FSM, pointer and counter live in the top module.

Test Plan:
- Reset, then req=4'b0001 -> grant_en=1, grant_idx=00 one cycle later; done pulse -> grant_en=0 next cycle, ptr=01.
- req=4'b1111 held, done pulsed each grant -> grant_idx sequence 00,01,10,11,00 with one grant_en=0 cycle between each.
- ptr=11, req=4'b1001 -> grant_idx=11; after release, ptr wraps to 00 and the next grant is 00.
- Owner 10 drops req[2] while granted, no done -> grant_en falls next cycle; ptr=11.
- rst_n=0 mid-grant with grant_idx=10 -> grant_en=0 immediately (asynchronously), grant_idx=00, busy=0.
- With ARB_TIMEOUT_EN and MAX_HOLD=4: req=4'b0100 held, no done -> grant_en high exactly 4 cycles, timeout pulses once, then regrant to 10 after one idle cycle.
